// File: rtl/inst_sram_responder.sv
// Instruction SRAM responder: byte-enabled word bank with RD_LAT-deep read/error pipeline.
// Optional request counters are enabled by defining INST_SRAM_STATS_EN.
module inst_sram_responder #(
  parameter int          ADDR_W    = 12,
  parameter logic [31:0] BASE_ADDR = 32'hbfc00000,
  parameter int          RD_LAT    = 1,
  parameter              INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_sram_en,
  input  logic [3:0]  inst_sram_wen,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic [31:0] inst_sram_rdata,
  output logic        inst_sram_rvalid,
  output logic        inst_sram_err
`ifdef INST_SRAM_STATS_EN
  ,
  output logic [31:0] rd_cnt,
  output logic [31:0] wr_cnt,
  output logic [15:0] err_cnt
`endif
);

  localparam int          DEPTH      = 1 << ADDR_W;
  localparam logic [32:0] BANK_BYTES = 33'(DEPTH) << 2;

  generate
    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
      $error("inst_sram_responder: RD_LAT=%0d outside legal range 1..4", RD_LAT);
    end
  endgenerate

  logic [31:0]       mem [DEPTH];
  logic [31:0]       off;
  logic              in_range;
  logic [ADDR_W-1:0] idx;
  logic              req_rd;
  logic              req_wr;
  logic              req_err;
  logic [31:0]       req_data;

  // Request decode; the offset subtraction wraps so addresses below the base fall out of range.
  always_comb begin
    off      = inst_sram_addr - BASE_ADDR;
    in_range = ({1'b0, off} < BANK_BYTES) && (inst_sram_addr[1:0] == 2'b00);
    idx      = off[ADDR_W+1:2];
    req_rd   = inst_sram_en && (inst_sram_wen == 4'h0);
    req_wr   = inst_sram_en && (inst_sram_wen != 4'h0) && in_range;
    req_err  = inst_sram_en && !in_range;
    req_data = in_range ? mem[idx] : 32'h0;
  end

  always_ff @(posedge clk) begin
    if (req_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (inst_sram_wen[i]) mem[idx][8*i +: 8] <= inst_sram_wdata[8*i +: 8];
      end
    end
  end

  logic        last_rd;
  logic        last_err;
  logic [31:0] last_data;

  generate
    if (RD_LAT <= 1) begin : g_direct
      assign last_rd   = req_rd;
      assign last_err  = req_err;
      assign last_data = req_data;
    end else begin : g_pipe
      logic [RD_LAT-2:0] vld_p;
      logic [RD_LAT-2:0] err_p;
      logic [31:0]       data_p [RD_LAT-1];

      // Stages p0..p(RD_LAT-2): array sampled at the request edge, then aged one stage per cycle.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld_p <= '0;
          err_p <= '0;
        end else begin
          vld_p[0] <= req_rd;
          err_p[0] <= req_err;
          for (int k = 1; k < RD_LAT - 1; k++) begin
            vld_p[k] <= vld_p[k-1];
            err_p[k] <= err_p[k-1];
          end
        end
      end

      always_ff @(posedge clk) begin
        data_p[0] <= req_data;
        for (int k = 1; k < RD_LAT - 1; k++) data_p[k] <= data_p[k-1];
      end

      assign last_rd   = vld_p[RD_LAT-2];
      assign last_err  = err_p[RD_LAT-2];
      assign last_data = data_p[RD_LAT-2];
    end
  endgenerate

  // Output stage: rdata only moves when a read retires, so it holds across idle cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_sram_rvalid <= 1'b0;
      inst_sram_err    <= 1'b0;
      inst_sram_rdata  <= 32'h0;
    end else begin
      inst_sram_rvalid <= last_rd;
      inst_sram_err    <= last_err;
      if (last_rd) inst_sram_rdata <= last_data;
    end
  end

`ifdef INST_SRAM_STATS_EN
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hffff_ffff) ? v : v + 32'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hffff) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt  <= 32'h0;
      wr_cnt  <= 32'h0;
      err_cnt <= 16'h0;
    end else begin
      if (req_rd)  rd_cnt  <= sat_inc32(rd_cnt);
      if (req_wr)  wr_cnt  <= sat_inc32(wr_cnt);
      if (req_err) err_cnt <= sat_inc16(err_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_inst_sram_responder.sv
// Scoreboard bench for inst_sram_responder: three instances (RD_LAT 1..3) share one stimulus stream.
module tb_inst_sram_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [3:0]  wen = 4'h0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;

  logic [31:0] rdata_o  [3];
  logic        rvalid_o [3];
  logic        err_o    [3];
`ifdef INST_SRAM_STATS_EN
  logic [31:0] rd_cnt_o  [3];
  logic [31:0] wr_cnt_o  [3];
  logic [15:0] err_cnt_o [3];
`endif

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    int          cyc;
    logic        rd;
    logic        er;
    logic [31:0] data;
  } exp_t;

  exp_t        sb [3][$];
  logic [31:0] last_d [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    inst_sram_responder #(.RD_LAT(g + 1)) u_dut (
      .clk              (clk),
      .rst              (rst),
      .inst_sram_en     (en),
      .inst_sram_wen    (wen),
      .inst_sram_addr   (addr),
      .inst_sram_wdata  (wdata),
      .inst_sram_rdata  (rdata_o[g]),
      .inst_sram_rvalid (rvalid_o[g]),
      .inst_sram_err    (err_o[g])
`ifdef INST_SRAM_STATS_EN
      ,
      .rd_cnt           (rd_cnt_o[g]),
      .wr_cnt           (wr_cnt_o[g]),
      .err_cnt          (err_cnt_o[g])
`endif
    );
  end

  task automatic chk(input string nm, input int d, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s dut_lat%0d cyc=%0d got=%h want=%h", nm, d + 1, cyc, got, want);
    end
  endtask

  // Monitor: every cycle each instance must either retire its scoreboard head or stay silent.
  exp_t        e;
  logic        want_v;
  logic        want_e;
  logic [31:0] want_d;
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      want_v = 1'b0;
      want_e = 1'b0;
      want_d = last_d[d];
      while (sb[d].size() > 0 && sb[d][0].cyc < cyc) begin
        e = sb[d].pop_front();
        chk("missed_retire", d, 32'(e.cyc), 32'(cyc));
      end
      if (rst) begin
        want_d = 32'h0;
      end else if (sb[d].size() > 0 && sb[d][0].cyc == cyc) begin
        e = sb[d].pop_front();
        want_v = e.rd;
        want_e = e.er;
        if (e.rd) want_d = e.data;
      end
      chk("rvalid", d, 32'(rvalid_o[d]), 32'(want_v));
      chk("err", d, 32'(err_o[d]), 32'(want_e));
      chk("rdata", d, rdata_o[d], want_d);
      last_d[d] = want_d;
    end
  end

  task automatic req(input logic [3:0] w, input logic [31:0] a, input logic [31:0] wd,
                     input logic ex_rd, input logic ex_er, input logic [31:0] ex_data);
    exp_t x;
    en = 1'b1;
    wen = w;
    addr = a;
    wdata = wd;
    if (ex_rd || ex_er) begin
      for (int d = 0; d < 3; d++) begin
        x.cyc = cyc + d + 1;
        x.rd = ex_rd;
        x.er = ex_er;
        x.data = ex_data;
        sb[d].push_back(x);
      end
    end
    @(negedge clk);
    en = 1'b0;
    wen = 4'h0;
  endtask

  task automatic wr(input logic [3:0] w, input logic [31:0] a, input logic [31:0] wd);
    req(w, a, wd, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic wr_bad(input logic [31:0] a, input logic [31:0] wd);
    req(4'hF, a, wd, 1'b0, 1'b1, 32'h0);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp_data);
    req(4'h0, a, 32'h0, 1'b1, 1'b0, exp_data);
  endtask

  task automatic rd_bad(input logic [31:0] a);
    req(4'h0, a, 32'h0, 1'b1, 1'b1, 32'h0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    for (int d = 0; d < 3; d++) last_d[d] = 32'h0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk("reset_rvalid", d, 32'(rvalid_o[d]), 32'h0);
      chk("reset_err", d, 32'(err_o[d]), 32'h0);
      chk("reset_rdata", d, rdata_o[d], 32'h0);
    end
    rst = 1'b0;
    idle(1);

    // Full write, immediate readback, then byte-lane merge.
    wr(4'hF, 32'hbfc00010, 32'hDEADBEEF);
    rd(32'hbfc00010, 32'hDEADBEEF);
    wr(4'b0101, 32'hbfc00010, 32'h11223344);
    rd(32'hbfc00010, 32'hDE22BE44);

    // Back-to-back reads after filling four words.
    wr(4'hF, 32'hbfc00000, 32'h01234567);
    wr(4'hF, 32'hbfc00004, 32'h89ABCDEF);
    wr(4'hF, 32'hbfc00008, 32'h0F1E2D3C);
    wr(4'hF, 32'hbfc0000C, 32'h4B5A6978);
    idle(1);
    rd(32'hbfc00000, 32'h01234567);
    rd(32'hbfc00004, 32'h89ABCDEF);
    rd(32'hbfc00008, 32'h0F1E2D3C);
    rd(32'hbfc0000C, 32'h4B5A6978);
    idle(6);

    // Error cases and the top-of-bank boundary (16 KiB bank).
    rd_bad(32'hbfc00002);
    rd_bad(32'h00000000);
    wr_bad(32'hbfc00001, 32'hFFFFFFFF);
    rd(32'hbfc00000, 32'h01234567);
    rd_bad(32'hbfc04000);
    wr(4'hF, 32'hbfc03ffc, 32'h55AA55AA);
    rd(32'hbfc03ffc, 32'h55AA55AA);
    idle(6);

    // Read in flight when reset pulses: nothing may retire afterwards.
    en = 1'b1;
    wen = 4'h0;
    addr = 32'hbfc00010;
    @(posedge clk);
    #1;
    en = 1'b0;
    rst = 1'b1;
    for (int d = 0; d < 3; d++) sb[d].delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    idle(5);

    // Memory survives reset; this stretch also feeds the counters.
    wr(4'hF, 32'hbfc00020, 32'hCAFEF00D);
    wr(4'hF, 32'hbfc00024, 32'h13579BDF);
    rd(32'hbfc00010, 32'hDE22BE44);
    rd(32'hbfc00004, 32'h89ABCDEF);
    rd(32'hbfc00020, 32'hCAFEF00D);
    rd(32'hbfc00024, 32'h13579BDF);
    rd(32'hbfc0000C, 32'h4B5A6978);
    rd_bad(32'hbfc00003);
    idle(6);

    for (int d = 0; d < 3; d++) begin
      chk("scoreboard_drained", d, 32'(sb[d].size()), 32'h0);
`ifdef INST_SRAM_STATS_EN
      chk("rd_cnt", d, rd_cnt_o[d], 32'd6);
      chk("wr_cnt", d, wr_cnt_o[d], 32'd2);
      chk("err_cnt", d, 32'(err_cnt_o[d]), 32'd1);
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
